// File: rtl/encrypt_function_3.sv
// encrypt_function_3 - transmit-side stage-3 masking encryptor.
// Takes a 60-bit plaintext and a 6-bit tag. It draws an 11-bit key (rand_9)
// from an internal Fibonacci LFSR. It adds a key-derived pattern b to {p, x0}
// modulo 2^61 and emits the packet {y[60:0], rand_9[10:0], tag[5:0]}.
// Optional feature macro: ENC3_PARITY_EN. When it is defined, x0 carries the
// even parity of p. When it is undefined, x0 is tied to zero.
module encrypt_function_3 #(
    parameter logic [10:0] SEED     = 11'h5A5,
    parameter logic [10:0] TAP_MASK = 11'h500
) (
    input  logic        Clk,
    input  logic        Rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [59:0] in_data,
    input  logic [5:0]  in_tag,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [77:0] out_data,
    output logic [10:0] lfsr_state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MASK = 2'd1,
        SUM  = 2'd2,
        HOLD = 2'd3
    } state_t;

    state_t      state_r;
    state_t      state_s;
    logic        in_ready_r;
    logic        out_valid_r;
    logic [77:0] out_data_r;
    logic [10:0] lfsr_r;
    logic [59:0] p_r;
    logic [5:0]  tag_r;
    logic [10:0] rand_r;
    logic [60:0] x_r;
    logic [59:0] b_r;
    logic        accept_s;
    logic        x0_s;
    logic [60:0] y_s;

    // Even parity of a plaintext word.
    function automatic logic parity60(input logic [59:0] v);
        return ^v;
    endfunction

    // One Fibonacci LFSR step. The all-zero lock-up state is escaped to 1.
    function automatic logic [10:0] lfsr_step(input logic [10:0] v);
        logic [10:0] nxt;
        if (v == 11'h000) begin
            nxt = 11'h001;
        end else begin
            nxt = {v[9:0], ^(v & TAP_MASK)};
        end
        return nxt;
    endfunction

    // Key-derived mask pattern b. The two inverted fields stop an all-zero
    // or all-one key from producing a trivial mask.
    function automatic logic [59:0] build_mask(input logic [10:0] r);
        return {r[4:0], r, ~r, r, r, ~r};
    endfunction

    assign accept_s   = (state_r == IDLE) && in_valid && in_ready_r;
    assign y_s        = x_r + {1'b0, b_r};
    assign in_ready   = in_ready_r;
    assign out_valid  = out_valid_r;
    assign out_data   = out_data_r;
    assign lfsr_state = lfsr_r;

    // Select the low bit of x: the parity observable, or zero.
    always_comb begin
        x0_s = 1'b0;
`ifdef ENC3_PARITY_EN
        x0_s = parity60(p_r);
`else
        x0_s = 1'b0;
`endif
    end

    // Next-state logic of the accept/mask/sum/hold sequence.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    state_s = MASK;
                end else begin
                    state_s = IDLE;
                end
            end
            MASK: state_s = SUM;
            SUM:  state_s = HOLD;
            HOLD: begin
                if (out_ready) begin
                    state_s = IDLE;
                end else begin
                    state_s = HOLD;
                end
            end
            default: state_s = IDLE;
        endcase
    end

    // State register and the registered in_ready. in_ready stays low until the
    // first clock edge after reset release, which synchronises the release.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_r    <= IDLE;
            in_ready_r <= 1'b0;
        end else begin
            state_r    <= state_s;
            in_ready_r <= (state_s == IDLE);
        end
    end

    // Capture the accepted word, then build x and b one cycle later.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            p_r    <= 60'd0;
            tag_r  <= 6'd0;
            rand_r <= 11'd0;
            x_r    <= 61'd0;
            b_r    <= 60'd0;
        end else begin
            if (accept_s) begin
                p_r    <= in_data;
                tag_r  <= in_tag;
                rand_r <= lfsr_r;
            end
            if (state_r == MASK) begin
                x_r <= {p_r, x0_s};
                b_r <= build_mask(rand_r);
            end
        end
    end

    // The key generator advances only when a word is accepted.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            lfsr_r <= SEED;
        end else if (accept_s) begin
            lfsr_r <= lfsr_step(lfsr_r);
        end
    end

    // Register the packet. It is held stable until downstream takes it.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            out_valid_r <= 1'b0;
            out_data_r  <= 78'd0;
        end else begin
            case (state_r)
                SUM: begin
                    out_valid_r <= 1'b1;
                    out_data_r  <= {y_s, rand_r, tag_r};
                end
                HOLD: begin
                    if (out_ready) begin
                        out_valid_r <= 1'b0;
                    end
                end
                default: begin
                    out_valid_r <= out_valid_r;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_encrypt_function_3.sv
// Scoreboard bench for encrypt_function_3: the driver pushes model packets and
// the monitor pops and compares them when the output handshake completes.
module tb_encrypt_function_3;

    localparam logic [10:0] TB_SEED = 11'h7FF;

    logic        Clk;
    logic        Rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [59:0] in_data;
    logic [5:0]  in_tag;
    logic        out_valid;
    logic        out_ready;
    logic [77:0] out_data;
    logic [10:0] lfsr_state;

    typedef struct {
        logic [77:0] pkt;
        logic [59:0] p;
    } exp_t;

    exp_t        sb_q[$];
    int          total = 0;
    int          bad = 0;
    int          ready_mode = 0;   // 0 random, 1 held low, 2 held high
    int          counting = 0;
    int          cnt[2048];
    logic [10:0] model_lfsr;

    encrypt_function_3 #(.SEED(TB_SEED), .TAP_MASK(11'h500)) dut (
        .Clk(Clk), .Rst_n(Rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_tag(in_tag), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .lfsr_state(lfsr_state)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Mask pattern b as plain integer arithmetic on the key value.
    function automatic logic [63:0] model_b(input logic [10:0] r);
        logic [63:0] rv;
        logic [63:0] nv;
        rv = 64'(r);
        nv = rv ^ 64'h7FF;
        return nv + (rv << 11) + (rv << 22) + (nv << 33) + (rv << 44) + ((rv & 64'h1F) << 55);
    endfunction

    function automatic logic [77:0] model_pkt(input logic [59:0] p, input logic [5:0] tag,
                                              input logic [10:0] r);
        logic [63:0] x;
        logic [63:0] y;
        x = 64'(p) * 64'd2;
`ifdef ENC3_PARITY_EN
        x = x + 64'($countones(p) % 2);
`endif
        y = (x + model_b(r)) % (64'd1 << 61);
        return {y[60:0], r, tag};
    endfunction

    // Receiver view: subtract b modulo 2^61 and drop x[0].
    function automatic logic [59:0] model_decrypt(input logic [60:0] y, input logic [10:0] r);
        logic [63:0] d;
        d = ((64'(y) + (64'd1 << 61)) - model_b(r)) % (64'd1 << 61);
        return d[60:1];
    endfunction

    function automatic logic [10:0] model_next(input logic [10:0] l);
        int v;
        int fb;
        v = int'(l);
        if (v == 0) return 11'h001;
        fb = ((v >> 10) ^ (v >> 8)) & 1;
        return 11'(((v * 2) % 2048) + fb);
    endfunction

    // Downstream ready generator.
    initial begin
        out_ready = 1'b0;
        forever begin
            @(posedge Clk);
            #1;
            if (ready_mode == 0) out_ready = ($urandom_range(0, 3) != 0);
            else if (ready_mode == 2) out_ready = 1'b1;
            else out_ready = 1'b0;
        end
    end

    // Monitor: pops an expected packet on each completed output handshake.
    initial begin
        logic [77:0] prev_data;
        logic        have_prev;
        logic        prev_taken;
        exp_t        e;
        int          idx;
        have_prev = 1'b0;
        prev_taken = 1'b0;
        prev_data = 78'd0;
        forever begin
            @(negedge Clk);
            if (!Rst_n || !out_valid) begin
                have_prev = 1'b0;
            end else begin
                check("busy_in_ready", in_ready, 0);
                if (have_prev && !prev_taken) check("hold_stable", out_data, prev_data);
                if (out_ready) begin
                    if (sb_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_packet: got %h expected none", out_data);
                    end else begin
                        e = sb_q.pop_front();
                        check("packet", out_data, e.pkt);
                        check("decrypt", model_decrypt(out_data[77:17], out_data[16:6]), e.p);
                        if (counting != 0) begin
                            idx = int'(out_data[16:6]);
                            cnt[idx]++;
                        end
                    end
                end
                prev_data = out_data;
                have_prev = 1'b1;
                prev_taken = out_ready;
            end
        end
    end

    // Offer one word and wait (bounded) for it to be accepted.
    task automatic send(input logic [59:0] p, input logic [5:0] tag);
        bit accepted;
        in_valid = 1'b1;
        in_data = p;
        in_tag = tag;
        accepted = 1'b0;
        for (int i = 0; i < 200 && !accepted; i++) begin
            @(negedge Clk);
            if (in_ready) begin
                check("lfsr_before_accept", lfsr_state, model_lfsr);
                sb_q.push_back('{model_pkt(p, tag, model_lfsr), p});
                model_lfsr = model_next(model_lfsr);
                accepted = 1'b1;
            end
        end
        if (!accepted) begin
            total++;
            bad++;
            $display("FAIL accept_timeout: got in_ready=0 expected 1");
        end
        @(posedge Clk);
        #1;
        in_valid = 1'b0;
        in_data = 60'({$urandom(), $urandom()});
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < 2000) begin
            @(negedge Clk);
            n++;
        end
        if (sb_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain_timeout: got %0d pending expected 0", sb_q.size());
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [77:0] cap;
        logic [10:0] cap_l;
        int          nbad;
        int          k;
        Rst_n = 1'b0;
        in_valid = 1'b0;
        in_data = 60'd0;
        in_tag = 6'd0;
        model_lfsr = TB_SEED;
        for (int i = 0; i < 2048; i++) cnt[i] = 0;
        #23;
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 0);
        check("rst_out_data", out_data, 0);
        check("rst_lfsr", lfsr_state, TB_SEED);
        #4;
        Rst_n = 1'b1;
        #1;
        check("release_in_ready_low", in_ready, 0);
        @(posedge Clk);
        #1;
        check("release_in_ready_high", in_ready, 1);

        // Directed packets with a latency check on the first one.
        ready_mode = 2;
        send(60'h0, 6'h2A);
        check("lat_mask", out_valid, 0);
        @(posedge Clk);
        #1;
        check("lat_sum", out_valid, 0);
        @(posedge Clk);
        #1;
        check("lat_hold", out_valid, 1);
        check("lfsr_after_first", lfsr_state, 11'h7FE);
        drain();
        send(60'hFFF_FFFF_FFFF_FFFF, 6'h15);
        drain();

        // Stall: downstream holds ready low for ten cycles.
        ready_mode = 1;
        @(posedge Clk);
        send(60'({$urandom(), $urandom()}), 6'($urandom()));
        k = 0;
        while (!out_valid && k < 20) begin
            @(negedge Clk);
            k++;
        end
        check("stall_valid", out_valid, 1);
        cap = out_data;
        cap_l = lfsr_state;
        for (int i = 0; i < 10; i++) begin
            @(negedge Clk);
            check("stall_data", out_data, cap);
            check("stall_in_ready", in_ready, 0);
            check("stall_lfsr", lfsr_state, cap_l);
        end
        ready_mode = 2;
        @(posedge Clk);
        @(negedge Clk);
        @(posedge Clk);
        #1;
        check("release_out_valid", out_valid, 0);
        check("release_idle", in_ready, 1);
        drain();

        // Reset while the packet sits in SUM.
        send(60'({$urandom(), $urandom()}), 6'($urandom()));
        @(posedge Clk);
        #1;
        Rst_n = 1'b0;
        #1;
        check("abort_out_valid", out_valid, 0);
        check("abort_in_ready", in_ready, 0);
        check("abort_out_data", out_data, 0);
        check("abort_lfsr", lfsr_state, TB_SEED);
        sb_q.delete();
        model_lfsr = TB_SEED;
        #2;
        Rst_n = 1'b1;
        @(posedge Clk);
        #1;
        check("abort_recover", in_ready, 1);

        // Full LFSR period with random traffic.
        ready_mode = 0;
        counting = 1;
        for (int i = 0; i < 2047; i++) begin
            send(60'({$urandom(), $urandom()}), 6'($urandom()));
            repeat ($urandom_range(0, 1)) @(posedge Clk);
        end
        drain();
        counting = 0;
        nbad = 0;
        for (int i = 0; i < 2048; i++) begin
            if (i == 0 && cnt[i] != 0) nbad++;
            if (i != 0 && cnt[i] != 1) nbad++;
        end
        check("period_coverage", nbad, 0);
        check("period_repeat_seed", lfsr_state, TB_SEED);
        send(60'h1, 6'h01);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/encrypt_function_3.md
Name: encrypt_function_3

Overview:
- Transmit-side counterpart of stage-3 decryption.
- Accepts a 60-bit plaintext word plus a 6-bit passthrough tag and draws an 11-bit random key from an internal LFSR.
- Masks the plaintext with the key-derived pattern b and emits the 78-bit packet that decrypt_function_3 consumes.
- Sits between the upstream stage-2 encryptor and the channel; uses a valid/ready handshake on both sides.

Parameters:
- SEED, 11'h5A5, LFSR value after reset; must be non-zero.
- TAP_MASK, 11'h500, feedback taps for x^11+x^9+1 (maximal length, period 2047).

Ports:
- Clk  input  1  rising-edge clock.
- Rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  plaintext word offered.
- in_ready  output  1  block can accept a word.
- in_data  input  60  plaintext p.
- in_tag  input  6  passthrough field, placed in out_data[5:0].
- out_valid  output  1  packet available.
- out_ready  input  1  downstream accepts packet.
- out_data  output  78  packet {y[60:0], rand_9[10:0], tag[5:0]}.
- lfsr_state  output  11  current LFSR value, debug only.

Behaviour:
- Reset (Rst_n low, asynchronous): state=IDLE, in_ready=0, out_valid=0, out_data=0, LFSR=SEED. Deassertion is synchronised internally; in_ready rises on the first Clk edge after release.
- FSM states: IDLE, MASK, SUM, HOLD.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready: latch p, tag and rand_9=LFSR; advance LFSR once; go to MASK.
- MASK:
  - in_ready=0.
  - Build b[59:0]:
    - b[10:0]=~rand_9
    - b[21:11]=rand_9
    - b[32:22]=rand_9
    - b[43:33]=~rand_9
    - b[54:44]=rand_9
    - b[59:55]=rand_9[4:0]
  - Build x[60:0]={p, x0}, with x0=0 (see Optional Feature).
  - Go to SUM.
- SUM:
  - Register y = (x + {1'b0,b}) mod 2^61; carry out of bit 60 is discarded, since the receiver subtracts modulo 2^61.
  - Register out_data = {y, rand_9, tag}; out_valid=1; go to HOLD.
- HOLD:
  - out_data stays stable while out_valid=1 and out_ready=0.
  - On out_ready: out_valid=0, go to IDLE.
- Latency: accept at edge N gives out_valid high after edge N+2. Throughput is one packet per 4 cycles minimum.
- LFSR:
  - Fibonacci form: next = {lfsr[9:0], ^(lfsr & TAP_MASK)}.
  - Advances only on an accepted input, never on stalls.
  - The all-zero state is unreachable. If forced by SEED=0, the LFSR reloads 11'h001.
- in_ready=0 in MASK, SUM and HOLD. in_valid during those states is ignored; upstream must hold it.
- out_ready asserted while out_valid=0 has no effect.
- Reset asserted mid-packet aborts the packet: out_valid drops immediately, the LFSR returns to SEED, and no partial packet is emitted.

Optional Feature:
- Macro ENC3_PARITY_EN.
- Defined: x0 = ^p (even-parity bit in x[0]). The receiver discards x[0], so the payload is unchanged; it gives a line checker a parity observable.
- Undefined: x0 = 0.

Test Plan:
- Reset, SEED=11'h7FF, send p=60'h0, tag=6'h2A -> out_data = {61'h0FFFF001FFFFF800, 11'h7FF, 6'h2A}, out_valid after 2 edges; next LFSR = 11'h7FE.
- p=60'hFFFFFFFFFFFFFFF, SEED=11'h7FF -> y wraps mod 2^61 with carry dropped. Feeding out_data into decrypt_function_3 gives outDec[59:0]=p.
- Stall: out_ready held 0 for 10 cycles -> out_data constant, in_ready=0, LFSR unchanged; release -> IDLE next edge.
- 2047 back-to-back packets -> rand_9 field visits every non-zero 11-bit value exactly once, then repeats SEED.
- Rst_n pulsed low while in SUM -> out_valid=0 asynchronously, and the next packet's rand_9 equals SEED.
- ENC3_PARITY_EN defined, p=60'h1 -> y[0]=1 after SUM; decrypt output still 60'h1.
